// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer.
//   seq_state_e : processor run state (IDLE, RUN, HALTED). The encoding is
//                 visible in waveforms as the sequencer's state register.
//   PC_RESET    : PC value held after a hard reset.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_e;

    localparam int PC_RESET = 0;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter, used for the retired-instruction count and reusable
// for other performance counters.
//   CLK   : clock, rising edge
//   Reset : synchronous active-high reset, clears count
//   clr   : synchronous clear, takes priority over inc
//   inc   : add one unless already at the all-ones maximum
//   count : current value, sticks at 2^W-1
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle core. Drives the instruction
// ROM address and consumes ALU control results (branch, soft reset, halt).
//
// Host handshake: Start is a one-cycle pulse, accepted only while idle or
// halted; it loads StartAddr into PC and clears the instruction count. Done is
// a level that rises on the edge after a halt instruction and stays high until
// the next accepted Start or a Reset. Start during RUN is ignored.
//
// Ports:
//   CLK, Reset          : clock and synchronous active-high reset
//   Start, StartAddr    : begin execution at StartAddr
//   Stall               : current instruction invalid, freeze PC and count
//   BrValid, BrOffset,
//   BrSign              : branch; PC +/- zext(BrOffset), modulo 2^PCW
//   AluReset, AluHalt   : ALU RST (soft reset to StartAddr, or halt)
//   PC                  : instruction fetch address
//   Running, Done       : state flags (RUN, HALTED)
//   InstCount           : saturating count of retired instructions
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PCW  = 10,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PCW-1:0]  StartAddr,
    input  logic            Stall,
    input  logic            BrValid,
    input  logic [7:0]      BrOffset,
    input  logic            BrSign,
    input  logic            AluReset,
    input  logic            AluHalt,
    output logic [PCW-1:0]  PC,
    output logic            Running,
    output logic            Done,
    output logic [CNTW-1:0] InstCount
);

    seq_state_e     state, state_n;
    logic [PCW-1:0] pc_n;
    logic [PCW-1:0] br_off;
    logic           cnt_clr;
    logic           cnt_inc;

    // Branch magnitude resized to the PC width; narrow PCs keep only the
    // low bits, which is equivalent under modulo-2^PCW arithmetic.
    generate
        if (PCW > 8) begin : g_off_wide
            assign br_off = {{(PCW-8){1'b0}}, BrOffset};
        end else if (PCW == 8) begin : g_off_eq
            assign br_off = BrOffset;
        end else begin : g_off_narrow
            assign br_off = BrOffset[PCW-1:0];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            PC    <= PCW'(PC_RESET);
        end else begin
            state <= state_n;
            PC    <= pc_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = PC;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (Start) begin
                    state_n = RUN;
                    pc_n    = StartAddr;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                // A stalled cycle retires nothing and ignores every ALU input.
                if (!Stall) begin
                    cnt_inc = 1'b1;
                    if (AluReset && AluHalt) begin
                        state_n = HALTED;
                    end else if (AluReset) begin
                        pc_n = StartAddr;
                    end else if (BrValid) begin
                        pc_n = BrSign ? (PC - br_off) : (PC + br_off);
                    end else begin
                        pc_n = PC + PCW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Flags decode straight from the state register, so they only move on
    // a clock edge.
    assign Running = (state == RUN);
    assign Done    = (state == HALTED);

    sat_counter #(
        .W(CNTW)
    ) u_inst_count (
        .CLK   (CLK),
        .Reset (Reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (InstCount)
    );

endmodule
